// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_pkg
// Purpose : Shared widths, NOP encoding and fetch FSM state type for the
//           16-bit PU instruction fetch stage.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================

`ifndef IFETCH_PKG_MACROS
`define IFETCH_PKG_MACROS
`define ASSERT 1'b1
`define NEGATE 1'b0
`endif

package ifetch_pkg;

   localparam int IF_AW = 8;
   localparam int IF_DW = 16;

   // All-zero word decodes as NOP, so the decoder raises no write strobes.
   localparam logic [IF_DW-1:0] IF_NOP = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2,
      HALT = 2'd3
   } if_state_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_pcnext.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_pcnext
// Purpose : Next-PC computation. Selects between sequential increment,
//           PC-relative target and absolute target; all results wrap
//           modulo 2^AW.
// Ports   : pc   in  AW  current program counter
//           pcwe in  1   taken jump/branch
//           pcs  in  1   1 = pc + ivs, 0 = jtgt
//           jtgt in  DW  absolute target (low AW bits used)
//           ivs  in  DW  signed offset (low AW bits used)
//           npc  out AW  next program counter
// Revision: 1.0  initial release
// ============================================================================

module ifetch_pcnext
   import ifetch_pkg::*;
#(
   parameter int AW = IF_AW,
   parameter int DW = IF_DW
) (
   input  logic [AW-1:0] pc,
   input  logic          pcwe,
   input  logic          pcs,
   input  logic [DW-1:0] jtgt,
   input  logic [DW-1:0] ivs,
   output logic [AW-1:0] npc
);

   logic [AW-1:0] seq_pc;
   logic [AW-1:0] rel_pc;

   // Truncating to AW bits makes two's-complement offsets work as
   // subtraction and gives the required wrap-around for free.
   assign seq_pc = pc + {{(AW-1){1'b0}}, 1'b1};
   assign rel_pc = pc + ivs[AW-1:0];

   always_comb begin
      npc = seq_pc;
      if (pcwe) begin
         npc = pcs ? rel_pc : jtgt[AW-1:0];
      end
   end

   // Upper operand bits beyond the PC width are intentionally discarded.
   generate
      if (DW > AW) begin : g_hi_drop
         logic unused_hi;
         assign unused_hi = ^{jtgt[DW-1:AW], ivs[DW-1:AW]};
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module  : ifetch
// Purpose : Instruction fetch stage. Owns the PC, issues req/ack reads to
//           instruction memory, presents one instruction per EXEC cycle to
//           the decoder and applies the decoder's halt/jump results.
// Ports   : clk, rst           clock, synchronous active-high reset
//           im_req/im_addr     memory read request and address (= pc)
//           im_ack/im_data     memory response, captured in the ack cycle
//           ir/ir_v            instruction to decoder (NOP when ir_v=0)
//           h/pcwe/pcs         decoder halt, jump taken, relative select
//           jtgt/ivs           absolute target / relative offset
//           pc, halted         program counter, permanent halt flag
//           stall_cnt          (IF_STALLCNT_EN only) REQ cycles without ack
// Config  : `define IF_STALLCNT_EN adds the saturating stall counter port.
// Revision: 1.0  initial release
// ============================================================================

module ifetch
   import ifetch_pkg::*;
#(
   parameter int AW = IF_AW,
   parameter int DW = IF_DW
) (
   input  logic          clk,
   input  logic          rst,
   output logic          im_req,
   output logic [AW-1:0] im_addr,
   input  logic          im_ack,
   input  logic [DW-1:0] im_data,
   output logic [DW-1:0] ir,
   output logic          ir_v,
   input  logic          h,
   input  logic          pcwe,
   input  logic          pcs,
   input  logic [DW-1:0] jtgt,
   input  logic [DW-1:0] ivs,
   output logic [AW-1:0] pc,
   output logic          halted
`ifdef IF_STALLCNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   if_state_t     state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] ir_q, ir_d;
   logic [AW-1:0] npc;

   ifetch_pcnext #(
      .AW (AW),
      .DW (DW)
   ) u_pcnext (
      .pc   (pc_q),
      .pcwe (pcwe),
      .pcs  (pcs),
      .jtgt (jtgt),
      .ivs  (ivs),
      .npc  (npc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Acks and decoder strobes only matter in the state that consumes them,
   // so a stray ack (e.g. left over from before a reset) has no effect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      im_req  = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            im_req = 1'b1;
            if (im_ack) begin
               ir_d    = im_data;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (h) begin
               state_d = HALT;
            end else begin
               pc_d    = npc;
               state_d = REQ;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign im_addr = pc_q;
   assign pc      = pc_q;
   assign ir_v    = (state_q == EXEC);
   assign halted  = (state_q == HALT);
   // Masking keeps the decoder from acting on a stale word.
   assign ir      = ir_v ? ir_q : IF_NOP;

`ifdef IF_STALLCNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 16'h0000;
      end else if ((state_q == REQ) && !im_ack && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'h0001;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch
// Purpose : Directed self-checking bench for ifetch with a behavioural
//           instruction memory of programmable ack latency.
// Revision: 1.0  initial release
// ============================================================================

module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        im_req;
   logic [7:0]  im_addr;
   logic        im_ack;
   logic [15:0] im_data;
   logic [15:0] ir;
   logic        ir_v;
   logic        h, pcwe, pcs;
   logic [15:0] jtgt, ivs;
   logic [7:0]  pc;
   logic        halted;
`ifdef IF_STALLCNT_EN
   logic [15:0] stall_cnt;
`endif

   logic [15:0] imem [0:255];
   logic [15:0] exp_w [0:2];
   int          ack_delay;
   int          req_cnt;
   logic        late_ack;
   int          n_total = 0;
   int          n_pass  = 0;

   always #5 clk = ~clk;

   ifetch u_dut (
      .clk     (clk),
      .rst     (rst),
      .im_req  (im_req),
      .im_addr (im_addr),
      .im_ack  (im_ack),
      .im_data (im_data),
      .ir      (ir),
      .ir_v    (ir_v),
      .h       (h),
      .pcwe    (pcwe),
      .pcs     (pcs),
      .jtgt    (jtgt),
      .ivs     (ivs),
      .pc      (pc),
      .halted  (halted)
`ifdef IF_STALLCNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // Memory model: acks after ack_delay unacknowledged request cycles;
   // late_ack injects an ack regardless of the request.
   assign im_ack  = (im_req && (req_cnt >= ack_delay)) || late_ack;
   assign im_data = imem[im_addr];

   always @(posedge clk) begin
      if (rst || !im_req) req_cnt <= 0;
      else if (!im_ack)   req_cnt <= req_cnt + 1;
   end

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      h = 1'b0; pcwe = 1'b0; pcs = 1'b0; jtgt = '0; ivs = '0; late_ack = 1'b0;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      h = 1'b1; pcwe = 1'b1; pcs = 1'b1; jtgt = 16'hFFFF; ivs = 16'hFFFF;
      late_ack = 1'b0; ack_delay = 0;
      rst = 1'b1;
      step;
      step;
      n_total++;
      if ({pc, im_req, ir_v, ir, halted} !== {8'h00, 1'b0, 1'b0, 16'h0000, 1'b0})
         $display("FAIL reset_state: got %h expected %h",
                  {pc, im_req, ir_v, ir, halted}, {8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
      else n_pass++;
      step;
      n_total++;
      if ({im_req, halted} !== 2'b00)
         $display("FAIL reset_hold: got %b expected %b", {im_req, halted}, 2'b00);
      else n_pass++;
      h = 1'b0; pcwe = 1'b0; pcs = 1'b0;
      rst = 1'b0;
      step;
      n_total++;
      if ({im_req, im_addr} !== {1'b1, 8'h00})
         $display("FAIL reset_first_req: got %h expected %h", {im_req, im_addr}, {1'b1, 8'h00});
      else n_pass++;
   endtask

   task automatic test_zero_latency;
      ack_delay = 0;
      do_reset;
      for (int i = 0; i < 3; i++) begin
         step;
         n_total++;
         if ({im_req, im_addr, im_ack, ir_v, ir} !== {1'b1, 8'(i), 1'b1, 1'b0, 16'h0000})
            $display("FAIL zl_req%0d: got %h expected %h", i,
                     {im_req, im_addr, im_ack, ir_v, ir}, {1'b1, 8'(i), 1'b1, 1'b0, 16'h0000});
         else n_pass++;
         step;
         n_total++;
         if ({im_req, ir_v, ir} !== {1'b0, 1'b1, exp_w[i]})
            $display("FAIL zl_exec%0d: got %h expected %h", i,
                     {im_req, ir_v, ir}, {1'b0, 1'b1, exp_w[i]});
         else n_pass++;
      end
`ifdef IF_STALLCNT_EN
      n_total++;
      if (stall_cnt !== 16'd0)
         $display("FAIL zl_stall_cnt: got %0d expected %0d", stall_cnt, 0);
      else n_pass++;
`endif
   endtask

   task automatic test_ack_delay;
      ack_delay = 3;
      do_reset;
      for (int i = 0; i < 3; i++) begin
         step;
         n_total++;
         if ({im_req, im_addr, im_ack, ir_v, ir} !== {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000})
            $display("FAIL dly_wait%0d: got %h expected %h", i,
                     {im_req, im_addr, im_ack, ir_v, ir}, {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000});
         else n_pass++;
      end
      step;
      n_total++;
      if ({im_req, im_addr, im_ack} !== {1'b1, 8'h00, 1'b1})
         $display("FAIL dly_ack: got %h expected %h", {im_req, im_addr, im_ack}, {1'b1, 8'h00, 1'b1});
      else n_pass++;
      step;
      n_total++;
      if ({ir_v, ir} !== {1'b1, 16'h0401})
         $display("FAIL dly_exec: got %h expected %h", {ir_v, ir}, {1'b1, 16'h0401});
      else n_pass++;
`ifdef IF_STALLCNT_EN
      n_total++;
      if (stall_cnt !== 16'd3)
         $display("FAIL dly_stall_cnt: got %0d expected %0d", stall_cnt, 3);
      else n_pass++;
`endif
      ack_delay = 0;
   endtask

   task automatic test_branch;
      ack_delay = 0;
      do_reset;
      step;                       // REQ @0
      step;                       // EXEC @0
      pcwe = 1'b1; pcs = 1'b0; jtgt = 16'h0010;
      step;
      n_total++;
      if ({im_req, im_addr, pc} !== {1'b1, 8'h10, 8'h10})
         $display("FAIL br_abs10: got %h expected %h", {im_req, im_addr, pc}, {1'b1, 8'h10, 8'h10});
      else n_pass++;
      step;                       // EXEC @10
      pcs = 1'b1; ivs = 16'hFFFC;
      step;
      n_total++;
      if ({im_req, im_addr} !== {1'b1, 8'h0C})
         $display("FAIL br_rel_neg: got %h expected %h", {im_req, im_addr}, {1'b1, 8'h0C});
      else n_pass++;
      step;                       // EXEC @0C
      n_total++;
      if (ir_v !== 1'b1)
         $display("FAIL br_exec_0c: got %b expected %b", ir_v, 1'b1);
      else n_pass++;
      pcs = 1'b0; jtgt = 16'h1234;
      step;
      n_total++;
      if ({im_req, im_addr} !== {1'b1, 8'h34})
         $display("FAIL br_abs34: got %h expected %h", {im_req, im_addr}, {1'b1, 8'h34});
      else n_pass++;
      pcwe = 1'b0;
   endtask

   task automatic test_wrap;
      ack_delay = 0;
      do_reset;
      step;
      step;                       // EXEC @0
      pcwe = 1'b1; pcs = 1'b0; jtgt = 16'h00FF;
      step;
      n_total++;
      if (im_addr !== 8'hFF)
         $display("FAIL wrap_to_ff: got %h expected %h", im_addr, 8'hFF);
      else n_pass++;
      step;                       // EXEC @FF
      pcwe = 1'b0;
      step;
      n_total++;
      if ({im_req, im_addr, pc} !== {1'b1, 8'h00, 8'h00})
         $display("FAIL wrap_seq: got %h expected %h", {im_req, im_addr, pc}, {1'b1, 8'h00, 8'h00});
      else n_pass++;
      step;                       // EXEC @00
      pcwe = 1'b1; pcs = 1'b0; jtgt = 16'hABFE;
      step;
      n_total++;
      if (im_addr !== 8'hFE)
         $display("FAIL wrap_to_fe: got %h expected %h", im_addr, 8'hFE);
      else n_pass++;
      step;                       // EXEC @FE
      pcs = 1'b1; ivs = 16'h0005;
      step;
      n_total++;
      if ({im_req, im_addr} !== {1'b1, 8'h03})
         $display("FAIL wrap_rel: got %h expected %h", {im_req, im_addr}, {1'b1, 8'h03});
      else n_pass++;
      pcwe = 1'b0; pcs = 1'b0;
   endtask

   task automatic test_halt;
      logic hold_ok;
      ack_delay = 0;
      imem[1] = 16'h0001;
      do_reset;
      step;                       // REQ @0
      step;                       // EXEC @0
      step;                       // REQ @1
      step;                       // EXEC @1
      n_total++;
      if ({ir_v, ir, pc} !== {1'b1, 16'h0001, 8'h01})
         $display("FAIL halt_word: got %h expected %h", {ir_v, ir, pc}, {1'b1, 16'h0001, 8'h01});
      else n_pass++;
      h = 1'b1; pcwe = 1'b1; pcs = 1'b0; jtgt = 16'h0055;
      step;
      n_total++;
      if ({halted, ir_v, im_req, pc, ir} !== {1'b1, 1'b0, 1'b0, 8'h01, 16'h0000})
         $display("FAIL halt_enter: got %h expected %h",
                  {halted, ir_v, im_req, pc, ir}, {1'b1, 1'b0, 1'b0, 8'h01, 16'h0000});
      else n_pass++;
      h = 1'b0; pcwe = 1'b0;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step;
         if (im_req || (pc != 8'h01) || !halted || ir_v) hold_ok = 1'b0;
      end
      n_total++;
      if (hold_ok !== 1'b1)
         $display("FAIL halt_hold: got %b expected %b", hold_ok, 1'b1);
      else n_pass++;
      rst = 1'b1;
      step;
      rst = 1'b0;
      n_total++;
      if ({pc, halted, im_req} !== {8'h00, 1'b0, 1'b0})
         $display("FAIL halt_reset: got %h expected %h", {pc, halted, im_req}, {8'h00, 1'b0, 1'b0});
      else n_pass++;
      step;
      n_total++;
      if ({im_req, im_addr} !== {1'b1, 8'h00})
         $display("FAIL halt_restart: got %h expected %h", {im_req, im_addr}, {1'b1, 8'h00});
      else n_pass++;
      imem[1] = 16'h0502;
   endtask

   task automatic test_rst_mid_req;
      ack_delay = 0;
      imem[8'h20] = 16'hBEEF;
      do_reset;
      step;
      step;                       // EXEC @0
      pcwe = 1'b1; pcs = 1'b0; jtgt = 16'h0020;
      ack_delay = 1;
      step;                       // REQ @20, first cycle, no ack
      n_total++;
      if ({im_req, im_addr, im_ack} !== {1'b1, 8'h20, 1'b0})
         $display("FAIL mid_req: got %h expected %h", {im_req, im_addr, im_ack}, {1'b1, 8'h20, 1'b0});
      else n_pass++;
      pcwe = 1'b0;
      rst = 1'b1;
      step;                       // reset edge lands mid-REQ
      rst = 1'b0;
      late_ack = 1'b1;
      #1;
      n_total++;
      if ({im_req, ir_v, pc, halted} !== {1'b0, 1'b0, 8'h00, 1'b0})
         $display("FAIL mid_idle: got %h expected %h", {im_req, ir_v, pc, halted}, {1'b0, 1'b0, 8'h00, 1'b0});
      else n_pass++;
      step;                       // IDLE -> REQ; late ack must be ignored
      late_ack = 1'b0;
      #1;
      n_total++;
      if ({im_req, im_addr, ir_v, ir} !== {1'b1, 8'h00, 1'b0, 16'h0000})
         $display("FAIL mid_req0: got %h expected %h",
                  {im_req, im_addr, ir_v, ir}, {1'b1, 8'h00, 1'b0, 16'h0000});
      else n_pass++;
      step;                       // second REQ cycle, ack arrives
      n_total++;
      if ({im_req, im_ack, ir_v} !== {1'b1, 1'b1, 1'b0})
         $display("FAIL mid_ack: got %b expected %b", {im_req, im_ack, ir_v}, {1'b1, 1'b1, 1'b0});
      else n_pass++;
      step;
      n_total++;
      if ({ir_v, ir} !== {1'b1, 16'h0401})
         $display("FAIL mid_exec: got %h expected %h", {ir_v, ir}, {1'b1, 16'h0401});
      else n_pass++;
      ack_delay = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      imem[0] = 16'h0401;
      imem[1] = 16'h0502;
      imem[2] = 16'h0000;
      exp_w[0] = 16'h0401;
      exp_w[1] = 16'h0502;
      exp_w[2] = 16'h0000;
      rst = 1'b1; h = 1'b0; pcwe = 1'b0; pcs = 1'b0;
      jtgt = '0; ivs = '0; late_ack = 1'b0; ack_delay = 0;

      test_reset;
      test_zero_latency;
      test_ack_delay;
      test_branch;
      test_wrap;
      test_halt;
      test_rst_mid_req;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ifetch.md
Name: ifetch

Overview:
Instruction fetch stage directly upstream of the instruction decoder in the 16-bit PU. It owns the program counter and issues variable-latency req/ack reads to instruction memory. It presents one instruction word at a time on the decoder's instruction input. It consumes the decoder's halt, PC-write and PC-select outputs to compute the next fetch address.

Parameters:
AW, 8, instruction memory address / PC width in bits (PC wraps modulo 2^AW)
DW, 16, instruction and data word width (equals `CMDS+1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
im_req  out  1  instruction memory read request
im_addr  out  AW  read address; equals pc while im_req=1
im_ack  in  1  memory response valid; im_data is captured in that cycle
im_data  in  DW  instruction word from memory
ir  out  DW  instruction to decoder input o; forced to 16'h0000 (NOP) whenever ir_v=0
ir_v  out  1  ir holds a valid instruction this cycle (EXEC state)
h  in  1  halt from decoder
pcwe  in  1  taken jump/branch from decoder
pcs  in  1  jump target select: 1 = pc + ivs (PC-relative), 0 = jtgt (absolute)
jtgt  in  DW  absolute target (ALU result); low AW bits used
ivs  in  DW  sign-extended immediate; low AW bits used, two's complement
pc  out  AW  current program counter
halted  out  1  fetch permanently stopped

Behaviour:
- Reset (rst=1 at an edge): pc=0, ir register=0, ir_v=0, im_req=0, halted=0, state=IDLE. Applies in any state, including mid-REQ. A late im_ack after reset is ignored because the FSM is in IDLE.
- States: IDLE, REQ, EXEC, HALT.
- IDLE:
  - im_req=0.
  - Goes to REQ on the next edge.
- REQ:
  - im_req=1 and im_addr=pc, both stable until ack.
  - If im_ack=1: the ir register captures im_data, ir_v becomes 1 and the state goes to EXEC on the same edge.
  - A same-cycle ack (combinational memory) is legal, so REQ lasts a minimum of 1 cycle.
  - im_ack outside REQ is ignored.
- EXEC:
  - Exactly one cycle; im_req=0. The decoder evaluates ir combinationally, and its h/pcwe/pcs are sampled at the closing edge.
  - Priority h > pcwe > sequential:
    - h=1: state HALT, pc unchanged, ir_v=0.
    - pcwe=1: pc <= pcs ? (pc + ivs[AW-1:0]) : jtgt[AW-1:0], truncated to AW bits.
    - otherwise: pc <= pc + 1; wraps from 2^AW-1 to 0.
  - For pcwe=1 and sequential cases, the state goes to REQ and ir_v goes to 0.
- HALT:
  - im_req=0, ir_v=0, halted=1.
  - Stays in HALT until rst.
- Minimum throughput: 2 cycles per instruction (REQ+EXEC).
- h, pcwe and pcs are ignored outside EXEC. Because ir=NOP when ir_v=0, the decoder never asserts we/dmwe outside EXEC.

Optional Feature:
IF_STALLCNT_EN:
- Defined:
  - Adds output port stall_cnt (16 bits): counts cycles spent in REQ with im_ack=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
  - Not incremented in IDLE, EXEC or HALT.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared header/package (pu.vh):
  - AW/DW widths and the NOP encoding 16'h0000.
  - `ASSERT/`NEGATE.
  - A 2-bit state enum if_state_t {IDLE, REQ, EXEC, HALT}.
- One combinational sub-module, pcnext: inputs pc, pcwe, pcs, jtgt, ivs; output npc. It holds the target mux and modulo-2^AW adders.
- The FSM and the pc/ir registers stay in ifetch.

Test Plan:
- Reset then zero-latency memory, ack same cycle, imem[0..2] = 16'h0401, 16'h0502, 16'h0000 -> fetch addresses 0,1,2 on alternate cycles; ir_v high every second cycle; ir=16'h0401 in first EXEC.
- Ack delayed 3 cycles at addr 0 -> im_req held 3 cycles with im_addr=0 stable; ir=NOP/ir_v=0 meanwhile; stall_cnt=3 when IF_STALLCNT_EN.
- EXEC at pc=8'h10 with pcwe=1, pcs=1, ivs=16'hFFFC -> next im_addr=8'h0C; pcs=0, jtgt=16'h1234 -> next im_addr=8'h34.
- pc=8'hFF sequential, and pc=8'hFE with PC-relative ivs=16'h0005 -> next addresses 8'h00 and 8'h03.
- HALT word 16'h0001 fetched with h=1 in EXEC -> halted=1, im_req stays 0 for 20 cycles, pc frozen; rst -> pc=0, fetch restarts.
- rst asserted during REQ while memory acks one cycle later -> ack ignored; IDLE then REQ at addr 0; ir_v stays 0 until the new ack.
